axis_rr_arbiter: RTL
====================

# axis_rr_arbiter

Round-robin arbiter that shares one axis output among COUNT axis input streams. Grants the output to one requester at a time for a bounded burst, or for a whole packet when packet mode is compiled in, then rotates priority. It sits in front of a shared sink, such as a small fifo, throttle or serializer, so that several producers can feed it without combinational loops between them.

## Interface
- WIDTH, 8, data width of every stream
- COUNT, 4, number of input streams (2..16)
- BURST, 4, maximum transfers per grant (1..256)
- SEL_WIDTH, $clog2(COUNT), width of grant index
- clock  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- idata  input  COUNT*WIDTH  input data, stream i at bits [i*WIDTH +: WIDTH]
- ivalid  input  COUNT  per-stream valid
- iready  output  COUNT  per-stream ready, combinational
- odata  output  WIDTH  shared output data, combinational mux of idata
- ovalid  output  1  shared output valid
- oready  input  1  shared output ready
- grant  output  SEL_WIDTH  registered index of current or most recent owner
- busy  output  1  registered, high while in GRANT state

## Operation
- FSM states: IDLE, GRANT.
- Reset values: state IDLE, grant = COUNT-1 (so that the first search starts at input 0), burst counter 0, busy 0.
- IDLE:
  - iready = 0, ovalid = 0, odata = idata of the grant index.
  - If any ivalid is high, select the first i with ivalid[i] high, searching (grant+1) mod COUNT, (grant+2) mod COUNT, and so on, wrapping.
  - Load grant = i, counter = 0, go to GRANT, set busy.
  - If no ivalid is high, stay in IDLE and hold grant.
- GRANT with g = grant:
  - ovalid = ivalid[g]; odata = idata[g]; iready[g] = oready; all other iready = 0.
  - Transfer = ivalid[g] && oready. On each transfer, counter increments.
  - Release to IDLE on the transfer that makes counter reach BURST.
  - Release to IDLE in any cycle where ivalid[g] is low. That cycle has no transfer.
  - grant is unchanged on release. It is the pointer for the next search.
- Counter width is $clog2(BURST+1). Counter is compared against BURST, with no wrap.
- A non-granted input that deasserts ivalid has no effect. Axis rules on the inputs (no ivalid drop before transfer) are the producers' responsibility. A drop by the owner is legal and simply ends its grant.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle t gives ovalid at t+1 at the earliest.
- One bubble cycle (IDLE) between consecutive grants. Sustained throughput is BURST/(BURST+1) when all inputs are saturated.
- Zero latency data path: ovalid, odata and iready follow the inputs combinationally in GRANT.
- Simultaneous requests are resolved purely by the rotating pointer. An input that just released has lowest priority on the next search.
- Reset asserted mid-burst: all outputs return to their reset values immediately (asynchronous). Any in-flight beat is not transferred.
- When oready is low in GRANT, the owner holds the grant indefinitely. There is no timeout.

## Configuration
- Macro: AXIS_RR_ARBITER_LAST_EN.
- Defined:
  - Adds port ilast (input, COUNT) and port olast (output, 1, = ilast[g] in GRANT, 0 in IDLE).
  - Release happens only on a transfer with ilast[g] high.
  - BURST and the counter are ignored.
  - ivalid[g] low does not release, so packets are never interleaved.
- Not defined: no last ports; burst and valid-drop release as above.

## Test plan
- Reset, all ivalid=1, oready=1, COUNT=4, BURST=4 -> grants 0,1,2,3,0; each grant gives 4 transfers followed by 1 idle cycle; busy pattern is 1111 0 repeating.
- Only ivalid[2]=1 with 2 beats then drop, oready=1 -> grant=2, 2 transfers, IDLE on the drop cycle, then re-grant to 2 when it reasserts.
- ivalid[1] and ivalid[3] high right after input 1 released -> grant goes to 3 before 1.
- Owner beat pending with oready held low for 10 cycles -> ovalid=1, iready[g]=0, odata stable, grant and busy unchanged.
- Reset pulsed during the third beat of a burst -> busy=0, grant=COUNT-1, all iready=0 the same cycle; the next search starts at input 0.
- With AXIS_RR_ARBITER_LAST_EN defined: input 0 sends a 7-beat packet with a mid-packet ivalid gap, and input 1 is requesting -> all 7 beats go out uninterrupted, olast=1 only on beat 7, then grant moves to 1.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin arbiter sharing one AXI-Stream output among
// COUNT input streams. A grant lasts up to BURST transfers, or ends early
// when the owner drops ivalid. Priority then rotates to the next requester.
// Optional feature macro: AXIS_RR_ARBITER_LAST_EN. When it is defined, a
// grant lasts for one whole packet, ending on the beat that carries ilast.
module axis_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int COUNT     = 4,
    parameter int BURST     = 4,
    parameter int SEL_WIDTH = $clog2(COUNT)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COUNT*WIDTH-1:0] idata,
    input  logic [COUNT-1:0]       ivalid,
    output logic [COUNT-1:0]       iready,
    output logic [WIDTH-1:0]       odata,
    output logic                   ovalid,
    input  logic                   oready,
`ifdef AXIS_RR_ARBITER_LAST_EN
    input  logic [COUNT-1:0]       ilast,
    output logic                   olast,
`endif
    output logic [SEL_WIDTH-1:0]   grant,
    output logic                   busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [SEL_WIDTH-1:0] r_grant;
    logic [SEL_WIDTH-1:0] w_nextGrant;
    logic                 r_busy;
    logic [WIDTH-1:0]     w_lanes [COUNT];
    logic                 w_found;
    logic [SEL_WIDTH-1:0] w_pick;
    logic                 w_ownerValid;
    logic                 w_xfer;
    logic                 w_release;

`ifndef AXIS_RR_ARBITER_LAST_EN
    localparam int CNT_W = $clog2(BURST + 1);
    logic [CNT_W-1:0] r_count;
`endif

    // Split the flat data bus into one lane per input stream.
    for (genvar i = 0; i < COUNT; i++) begin : g_lanes
        assign w_lanes[i] = idata[i*WIDTH +: WIDTH];
    end

    // Owner-side handshake: the owner's valid and whether a beat moves this cycle.
    always_comb begin
        w_ownerValid = ivalid[r_grant];
        w_xfer       = (r_state == GRANT) && w_ownerValid && oready;
    end

    // Rotating search starting just after the last owner; walking the
    // candidates from farthest to nearest leaves the nearest requester picked.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_grant;
        for (int k = COUNT; k >= 1; k--) begin
            if (ivalid[SEL_WIDTH'((int'(r_grant) + k) % COUNT)]) begin
                w_found = 1'b1;
                w_pick  = SEL_WIDTH'((int'(r_grant) + k) % COUNT);
            end
        end
    end

    // When the current grant ends: on the packet's last beat, or on the
    // final beat of the burst or an owner valid drop.
    always_comb begin
`ifdef AXIS_RR_ARBITER_LAST_EN
        w_release = w_xfer && ilast[r_grant];
`else
        w_release = !w_ownerValid || (w_xfer && (r_count == CNT_W'(BURST - 1)));
`endif
    end

    // Next-state logic: IDLE picks a new owner, GRANT waits for release.
    always_comb begin
        w_nextState = r_state;
        w_nextGrant = r_grant;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nextState = GRANT;
                    w_nextGrant = w_pick;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Combinational data path: route the owner's stream straight through.
    always_comb begin
        iready = '0;
        ovalid = 1'b0;
        odata  = w_lanes[r_grant];
`ifdef AXIS_RR_ARBITER_LAST_EN
        olast  = 1'b0;
`endif
        if (r_state == GRANT) begin
            ovalid          = w_ownerValid;
            iready[r_grant] = oready;
`ifdef AXIS_RR_ARBITER_LAST_EN
            olast           = ilast[r_grant];
`endif
        end
    end

    // State, grant pointer and busy flag; reset points at COUNT-1 so the
    // first search begins at input 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= SEL_WIDTH'(COUNT - 1);
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_grant <= w_nextGrant;
            r_busy  <= (w_nextState == GRANT);
        end
    end

`ifndef AXIS_RR_ARBITER_LAST_EN
    // Beat counter for the current grant, cleared while waiting in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_state == IDLE) begin
            r_count <= '0;
        end else if (w_xfer) begin
            r_count <= r_count + 1'b1;
        end
    end
`endif

    assign grant = r_grant;
    assign busy  = r_busy;

endmodule
